vend_ctrl: RTL and testbench

//  Vending-machine sequencer: accumulates coin credit and latches the item selection.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_change_gen.sv | 103 ++++++++++
 rtl/vend_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_vend_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending-machine sequencer.
// Coin-by-coin change payout is enabled with VEND_COIN_CHANGE_EN.
package vend_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CREDIT   = 3'd1,
        ST_CHECK    = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_REFUND   = 3'd4,
        ST_CHANGE   = 3'd5
    } vend_state_e;

    // Front-panel coin codes
    localparam logic [1:0] COIN_5C   = 2'd0;
    localparam logic [1:0] COIN_10C  = 2'd1;
    localparam logic [1:0] COIN_25C  = 2'd2;
    localparam logic [1:0] COIN_100C = 2'd3;

    // Face value in cents of a coin code
    function automatic logic [7:0] coin_value(input logic [1:0] code);
        logic [7:0] val;
        case (code)
            COIN_5C:   val = 8'd5;
            COIN_10C:  val = 8'd10;
            COIN_25C:  val = 8'd25;
            COIN_100C: val = 8'd100;
            default:   val = 8'd0;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/vend_change_gen.sv
// Greedy change payout: issues one pulse per 25c/10c/5c coin, largest first,
// with PULSE_GAP-1 idle cycles after each pulse. Used only when
// VEND_COIN_CHANGE_EN is defined.
module vend_change_gen #(
    parameter int PULSE_GAP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] amount_i,
    output logic       coin_q_o,
    output logic       coin_d_o,
    output logic       coin_n_o,
    output logic       done_o,
    output logic [7:0] total_o
);
    import vend_pkg::*;

    localparam int GW = (PULSE_GAP > 2) ? $clog2(PULSE_GAP) : 1;

    logic          active_q;
    logic [7:0]    rem_q;
    logic [7:0]    total_q;
    logic [GW-1:0] gap_q;
    logic          coin_q_q;
    logic          coin_d_q;
    logic          coin_n_q;
    logic          done_q;
    logic [7:0]    total_out_q;

    logic          pick_q_d;
    logic          pick_d_d;
    logic          pick_n_d;
    logic [7:0]    rem_d;

    // Choose the largest coin that still fits into the remainder
    always_comb begin
        pick_q_d = 1'b0;
        pick_d_d = 1'b0;
        pick_n_d = 1'b0;
        rem_d    = rem_q;
        if (rem_q >= 8'd25) begin
            pick_q_d = 1'b1;
            rem_d    = rem_q - 8'd25;
        end else if (rem_q >= 8'd10) begin
            pick_d_d = 1'b1;
            rem_d    = rem_q - 8'd10;
        end else if (rem_q >= 8'd5) begin
            pick_n_d = 1'b1;
            rem_d    = rem_q - 8'd5;
        end
    end

    // Payout sequencer; a remainder below 5c cannot be paid in coins and ends the run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= 1'b0;
            rem_q       <= '0;
            total_q     <= '0;
            gap_q       <= '0;
            coin_q_q    <= 1'b0;
            coin_d_q    <= 1'b0;
            coin_n_q    <= 1'b0;
            done_q      <= 1'b0;
            total_out_q <= '0;
        end else begin
            coin_q_q    <= 1'b0;
            coin_d_q    <= 1'b0;
            coin_n_q    <= 1'b0;
            done_q      <= 1'b0;
            total_out_q <= '0;
            // Gap keeps counting across runs so back-to-back payouts stay spaced
            if (gap_q != '0) begin
                gap_q <= gap_q - GW'(1);
            end
            if (start_i) begin
                active_q <= 1'b1;
                rem_q    <= amount_i;
                total_q  <= amount_i;
            end else if (active_q && (gap_q == '0)) begin
                coin_q_q <= pick_q_d;
                coin_d_q <= pick_d_d;
                coin_n_q <= pick_n_d;
                rem_q    <= rem_d;
                if (pick_q_d || pick_d_d || pick_n_d) begin
                    gap_q <= GW'(PULSE_GAP - 1);
                end
                if (rem_d < 8'd5) begin
                    active_q    <= 1'b0;
                    done_q      <= 1'b1;
                    total_out_q <= total_q;
                end
            end
        end
    end

    assign coin_q_o = coin_q_q;
    assign coin_d_o = coin_d_q;
    assign coin_n_o = coin_n_q;
    assign done_o   = done_q;
    assign total_o  = total_out_q;

endmodule

// File: rtl/vend_ctrl.sv
// Vending-machine sequencer: coin credit, selection latch, price check,
// dispense timing, change and refund. Define VEND_COIN_CHANGE_EN to pay
// change as individual 25c/10c/5c pulses instead of a single lump value.
module vend_ctrl #(
    parameter int CREDIT_MAX = 255,
    parameter int DISP_LEN   = 3
`ifdef VEND_COIN_CHANGE_EN
    ,
    parameter int PULSE_GAP  = 4
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_valid,
    input  logic [1:0] coin_code,
    input  logic       sel_pulse,
    input  logic       cancel,
    input  logic [2:0] item_sel,
    input  logic [7:0] item_cost,
    output logic [2:0] item_sel_q,
    output logic [7:0] credit,
    output logic       dispense,
    output logic       short_fund,
    output logic       coin_reject,
    output logic       change_valid,
    output logic [7:0] change_amt,
`ifdef VEND_COIN_CHANGE_EN
    output logic       coin_q,
    output logic       coin_d,
    output logic       coin_n,
`endif
    output logic       busy
);
    import vend_pkg::*;

    localparam int DCW = (DISP_LEN > 2) ? $clog2(DISP_LEN) : 1;

    vend_state_e    state_q;
    logic [7:0]     credit_q;
    logic [7:0]     change_q;
    logic [DCW-1:0] disp_cnt_q;
    logic           dispense_q;
    logic           short_fund_q;
    logic           coin_reject_q;
`ifdef VEND_COIN_CHANGE_EN
    logic           chg_start_q;
    logic           chg_done;
    logic [7:0]     chg_total;
`else
    logic           change_valid_q;
    logic [7:0]     change_amt_q;
`endif

    logic [8:0]     coin_sum_d;
    logic           coin_open_d;
    logic           coin_ok_d;
    logic [7:0]     credit_d;

    // Coin acceptance: 9-bit sum so an overflow is refused rather than wrapped
    always_comb begin
        coin_sum_d  = {1'b0, credit_q} + {1'b0, coin_value(coin_code)};
        coin_open_d = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
        coin_ok_d   = coin_valid && coin_open_d && (coin_sum_d <= 9'(CREDIT_MAX));
        credit_d    = coin_ok_d ? coin_sum_d[7:0] : credit_q;
    end

    // Main sequencer with registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            change_q       <= '0;
            disp_cnt_q     <= '0;
            item_sel_q     <= '0;
            dispense_q     <= 1'b0;
            short_fund_q   <= 1'b0;
            coin_reject_q  <= 1'b0;
`ifdef VEND_COIN_CHANGE_EN
            chg_start_q    <= 1'b0;
`else
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
`endif
        end else begin
            short_fund_q   <= 1'b0;
            coin_reject_q  <= coin_valid && !coin_ok_d;
`ifdef VEND_COIN_CHANGE_EN
            chg_start_q    <= 1'b0;
`else
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
`endif
            case (state_q)
                ST_IDLE: begin
                    credit_q <= credit_d;
                    if (coin_ok_d) begin
                        state_q <= ST_CREDIT;
                    end
                end
                ST_CREDIT: begin
                    // A same-cycle coin is already folded into credit_d
                    credit_q <= credit_d;
                    if (cancel) begin
                        if (credit_d != '0) begin
                            state_q <= ST_REFUND;
                        end
                    end else if (sel_pulse) begin
                        item_sel_q <= item_sel;
                        state_q    <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (credit_q >= item_cost) begin
                        change_q   <= credit_q - item_cost;
                        credit_q   <= '0;
                        dispense_q <= 1'b1;
                        disp_cnt_q <= DCW'(DISP_LEN - 1);
                        state_q    <= ST_DISPENSE;
                    end else begin
                        short_fund_q <= 1'b1;
                        state_q      <= ST_CREDIT;
                    end
                end
                ST_DISPENSE: begin
                    if (disp_cnt_q == '0) begin
                        dispense_q <= 1'b0;
                        if (change_q != '0) begin
                            state_q <= ST_CHANGE;
`ifdef VEND_COIN_CHANGE_EN
                            chg_start_q    <= 1'b1;
`else
                            change_valid_q <= 1'b1;
                            change_amt_q   <= change_q;
`endif
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        disp_cnt_q <= disp_cnt_q - DCW'(1);
                    end
                end
                ST_REFUND: begin
                    change_q <= credit_q;
                    credit_q <= '0;
                    state_q  <= ST_CHANGE;
`ifdef VEND_COIN_CHANGE_EN
                    chg_start_q    <= 1'b1;
`else
                    change_valid_q <= 1'b1;
                    change_amt_q   <= credit_q;
`endif
                end
                ST_CHANGE: begin
`ifdef VEND_COIN_CHANGE_EN
                    if (chg_done) begin
                        state_q <= ST_IDLE;
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef VEND_COIN_CHANGE_EN
    // Coin-by-coin payout of change_q, started on entry to CHANGE
    vend_change_gen #(
        .PULSE_GAP (PULSE_GAP)
    ) u_change_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (chg_start_q),
        .amount_i (change_q),
        .coin_q_o (coin_q),
        .coin_d_o (coin_d),
        .coin_n_o (coin_n),
        .done_o   (chg_done),
        .total_o  (chg_total)
    );

    assign change_valid = chg_done;
    assign change_amt   = chg_total;
`else
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
`endif

    assign credit      = credit_q;
    assign dispense    = dispense_q;
    assign short_fund  = short_fund_q;
    assign coin_reject = coin_reject_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_CREDIT);

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed testbench for vend_ctrl with a small price-lookup table.
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       sel_pulse;
    logic       cancel;
    logic [2:0] item_sel;
    logic [7:0] item_cost;
    logic [2:0] item_sel_q;
    logic [7:0] credit;
    logic       dispense;
    logic       short_fund;
    logic       coin_reject;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       busy;
`ifdef VEND_COIN_CHANGE_EN
    logic       coin_q;
    logic       coin_d;
    logic       coin_n;
`endif

    logic [7:0] price_tbl [8];

    int checks = 0;
    int errors = 0;

    vend_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .coin_valid   (coin_valid),
        .coin_code    (coin_code),
        .sel_pulse    (sel_pulse),
        .cancel       (cancel),
        .item_sel     (item_sel),
        .item_cost    (item_cost),
        .item_sel_q   (item_sel_q),
        .credit       (credit),
        .dispense     (dispense),
        .short_fund   (short_fund),
        .coin_reject  (coin_reject),
        .change_valid (change_valid),
        .change_amt   (change_amt),
`ifdef VEND_COIN_CHANGE_EN
        .coin_q       (coin_q),
        .coin_d       (coin_d),
        .coin_n       (coin_n),
`endif
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // External price lookup, combinational on the latched selection
    always_comb item_cost = price_tbl[item_sel_q];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put_coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_code  = code;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic do_sel(input logic [2:0] s);
        item_sel  = s;
        sel_pulse = 1'b1;
        tick();
        sel_pulse = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // Run n cycles, counting dispense-high cycles and change_valid pulses
    task automatic run_out(input int n, output int n_disp, output int n_cv, output int amt);
        n_disp = 0;
        n_cv   = 0;
        amt    = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (dispense) n_disp++;
            if (change_valid) begin
                n_cv++;
                amt = int'(change_amt);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int nd, ncv, amt;
        price_tbl[0] = 8'd125;
        price_tbl[1] = 8'd50;
        price_tbl[2] = 8'd75;
        price_tbl[3] = 8'd100;
        price_tbl[4] = 8'd225;
        price_tbl[5] = 8'd150;
        price_tbl[6] = 8'd60;
        price_tbl[7] = 8'd255;
        rst_n      = 1'b0;
        coin_valid = 1'b0;
        coin_code  = 2'd0;
        sel_pulse  = 1'b0;
        cancel     = 1'b0;
        item_sel   = 3'd0;

        // Reset state
        tick();
        tick();
        check_eq("rst_credit", credit, 0);
        check_eq("rst_dispense", dispense, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_change_valid", change_valid, 0);
        check_eq("rst_item_sel_q", item_sel_q, 0);
        check_eq("rst_coin_reject", coin_reject, 0);
        rst_n = 1'b1;
        tick();

        // sel_pulse in IDLE is ignored
        do_sel(3'd6);
        check_eq("idle_sel_busy", busy, 0);
        check_eq("idle_sel_item", item_sel_q, 0);
        $display("TXN idle_sel item_sel_q=%0d busy=%0d", item_sel_q, busy);

        // Exact payment: 100+25 for item0 (125)
        put_coin(2'd3);
        check_eq("exact_credit100", credit, 100);
        put_coin(2'd2);
        check_eq("exact_credit125", credit, 125);
        do_sel(3'd0);
        check_eq("exact_check_busy", busy, 1);
        run_out(8, nd, ncv, amt);
        check_eq("exact_disp_len", nd, 3);
        check_eq("exact_no_change", ncv, 0);
        check_eq("exact_credit0", credit, 0);
        check_eq("exact_idle", busy, 0);
        $display("TXN exact dispense_cycles=%0d change_pulses=%0d", nd, ncv);

        // Overpay: 100+100+25 for item0 -> change 100
        put_coin(2'd3);
        put_coin(2'd3);
        put_coin(2'd2);
        check_eq("over_credit225", credit, 225);
        do_sel(3'd0);
        run_out(8, nd, ncv, amt);
        check_eq("over_disp_len", nd, 3);
        check_eq("over_change_cnt", ncv, 1);
        check_eq("over_change_amt", amt, 100);
        check_eq("over_credit0", credit, 0);
        $display("TXN overpay dispense_cycles=%0d change_amt=%0d", nd, amt);

        // Short funds: 50 credit, item4 (225)
        put_coin(2'd2);
        put_coin(2'd2);
        do_sel(3'd4);
        check_eq("short_item_latch", item_sel_q, 4);
        tick();
        check_eq("short_pulse", short_fund, 1);
        check_eq("short_credit", credit, 50);
        check_eq("short_busy", busy, 0);
        tick();
        check_eq("short_pulse_end", short_fund, 0);
        put_coin(2'd0);
        check_eq("short_credit_add", credit, 55);
        do_cancel();
        run_out(4, nd, ncv, amt);
        check_eq("short_refund_cnt", ncv, 1);
        check_eq("short_refund_amt", amt, 55);
        $display("TXN short_fund refund_amt=%0d", amt);

        // Cancel: 35 credit -> refund 35
        put_coin(2'd2);
        put_coin(2'd1);
        do_cancel();
        check_eq("cancel_refund_busy", busy, 1);
        check_eq("cancel_credit_hold", credit, 35);
        tick();
        check_eq("cancel_cv", change_valid, 1);
        check_eq("cancel_amt", change_amt, 35);
        check_eq("cancel_credit0", credit, 0);
        tick();
        check_eq("cancel_idle", busy, 0);
        check_eq("cancel_cv_end", change_valid, 0);
        $display("TXN cancel refund=35");

        // Coin during DISPENSE is rejected
        put_coin(2'd3);
        put_coin(2'd2);
        do_sel(3'd0);
        tick();
        check_eq("disp_active", dispense, 1);
        put_coin(2'd0);
        check_eq("disp_coin_reject", coin_reject, 1);
        check_eq("disp_coin_credit", credit, 0);
        run_out(6, nd, ncv, amt);
        check_eq("disp_drain_idle", busy, 0);
        $display("TXN coin_in_dispense reject=1");

        // Overflow: 200 + 100 refused; then sel+cancel+5c in one cycle refunds 205
        put_coin(2'd3);
        put_coin(2'd3);
        put_coin(2'd3);
        check_eq("ovf_reject", coin_reject, 1);
        check_eq("ovf_credit", credit, 200);
        item_sel   = 3'd5;
        sel_pulse  = 1'b1;
        cancel     = 1'b1;
        coin_valid = 1'b1;
        coin_code  = 2'd0;
        tick();
        sel_pulse  = 1'b0;
        cancel     = 1'b0;
        coin_valid = 1'b0;
        check_eq("selcan_busy", busy, 1);
        check_eq("selcan_no_latch", item_sel_q, 0);
        check_eq("selcan_credit", credit, 205);
        run_out(4, nd, ncv, amt);
        check_eq("selcan_refund_amt", amt, 205);
        check_eq("selcan_no_disp", nd, 0);
        $display("TXN overflow_selcancel refund=%0d", amt);

        // Boundary: exactly 255 accepted, one more 5c refused
        put_coin(2'd3);
        put_coin(2'd3);
        put_coin(2'd2);
        put_coin(2'd2);
        put_coin(2'd0);
        check_eq("max_credit", credit, 255);
        check_eq("max_accept", coin_reject, 0);
        put_coin(2'd0);
        check_eq("max_reject", coin_reject, 1);
        check_eq("max_credit_hold", credit, 255);
        do_cancel();
        run_out(4, nd, ncv, amt);
        check_eq("max_refund", amt, 255);
        $display("TXN boundary_255 refund=%0d", amt);

        // Async reset mid-dispense aborts at once
        put_coin(2'd3);
        put_coin(2'd2);
        do_sel(3'd0);
        tick();
        check_eq("ares_pre", dispense, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ares_dispense", dispense, 0);
        check_eq("ares_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        put_coin(2'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("ares_credit_lost", credit, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("TXN async_reset dispense=%0d credit=%0d", dispense, credit);

`ifdef VEND_COIN_CHANGE_EN
        // Coin payout: 100 credit, item6 (60) -> change 40 = 25 + 10 + 5
        begin
            int tq, td, tn, tcv, acv;
            tq = -1; td = -1; tn = -1; tcv = -1; acv = 0;
            put_coin(2'd3);
            do_sel(3'd6);
            for (int i = 0; i < 40; i++) begin
                tick();
                if (coin_q) tq = i;
                if (coin_d) td = i;
                if (coin_n) tn = i;
                if (change_valid) begin
                    tcv = i;
                    acv = int'(change_amt);
                end
            end
            check_eq("cc_q_seen", (tq >= 0), 1);
            check_eq("cc_q_to_d", td - tq, 4);
            check_eq("cc_d_to_n", tn - td, 4);
            check_eq("cc_cv_last", tcv, tn);
            check_eq("cc_total", acv, 40);
            check_eq("cc_idle", busy, 0);
            $display("TXN coin_change q@%0d d@%0d n@%0d total=%0d", tq, td, tn, acv);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
